// File: rtl/dictionary_stream_loader.sv
// dictionary_stream_loader
// Streams a column-major dictionary RAM into the phi array of the dictionary
// processor. Each beat carries LANES words. A credit-limited read pipeline
// keeps the output buffer from overflowing when the consumer stalls.
//
// Ports
//   clock, reset          single rising-edge clock, synchronous active-high reset
//   start, abort          one-cycle request (sampled in IDLE) / cancel in any state
//   col_first, col_count  column sub-range to load
//   busy, done, error     status: not idle / completion pulse / range error flag
//   ram_read_en/addr/data beat-wide RAM read port (data RAM_LATENCY cycles later)
//   out_valid/ready       valid/ready handshake toward the processor
//   out_data/row/col/last beat payload, its phi coordinates and end-of-transfer tag
module dictionary_stream_loader #(
  parameter int DATA_WIDTH      = 32,
  parameter int ROWS            = 64,
  parameter int COLS            = 256,
  parameter int LANES           = 1,
  parameter int RAM_LATENCY     = 1,
  parameter int FIFO_DEPTH      = RAM_LATENCY + 2,
  parameter int BEAT_ADDR_WIDTH = $clog2(ROWS * COLS / LANES)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [$clog2(COLS)-1:0]       col_first,
  input  logic [$clog2(COLS):0]         col_count,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic                          ram_read_en,
  output logic [BEAT_ADDR_WIDTH-1:0]    ram_read_addr,
  input  logic [LANES*DATA_WIDTH-1:0]   ram_read_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_WIDTH-1:0]   out_data,
  output logic [$clog2(ROWS)-1:0]       out_row,
  output logic [$clog2(COLS)-1:0]       out_col,
  output logic                          out_last
);

  localparam int CW      = $clog2(COLS);
  localparam int RW      = $clog2(ROWS);
  localparam int LW      = LANES * DATA_WIDTH;
  localparam int BPC     = ROWS / LANES;
  localparam int RANGE_W = CW + 2;
  localparam int PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW      = $clog2(FIFO_DEPTH + RAM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

  state_t               state;
  logic [RW-1:0]        row_q;
  logic [CW-1:0]        col_q;
  logic [CW-1:0]        last_col;
  logic [BEAT_ADDR_WIDTH-1:0] addr_q;

  logic [RAM_LATENCY-1:0] tag_vld_p;
  logic [RW-1:0]          tag_row_p  [RAM_LATENCY];
  logic [CW-1:0]          tag_col_p  [RAM_LATENCY];
  logic                   tag_last_p [RAM_LATENCY];

  logic [LW-1:0]        fifo_data [FIFO_DEPTH];
  logic [RW-1:0]        fifo_row  [FIFO_DEPTH];
  logic [CW-1:0]        fifo_col  [FIFO_DEPTH];
  logic                 fifo_last [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [NW-1:0]        count;

  logic [NW-1:0]        inflight, count_next, inflight_next;
  logic [RANGE_W-1:0]   range_end;
  logic                 range_bad, beat_last, issue, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Range check is done one bit wider than col_first+col_count so it cannot wrap.
  assign range_end = {2'b00, col_first} + {1'b0, col_count};
  assign range_bad = (col_count == '0) || (range_end > RANGE_W'(COLS));

  assign beat_last = (row_q == RW'(ROWS - LANES)) && (col_q == last_col);
  assign inflight  = NW'($countones(tag_vld_p));
  // Reads are only issued while buffered plus in-flight beats leave a free slot,
  // so every returning beat is guaranteed space in the buffer.
  assign issue     = (state == RUN) && !abort && ((count + inflight) < NW'(FIFO_DEPTH));
  assign push      = tag_vld_p[RAM_LATENCY-1];
  assign pop       = out_valid && out_ready;

  assign count_next    = count + NW'(push) - NW'(pop);
  assign inflight_next = inflight - NW'(push) + NW'(issue);

  assign ram_read_en   = issue;
  assign ram_read_addr = addr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      last_col <= '0;
      addr_q   <= '0;
    end else if (abort) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (range_bad) begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              error    <= 1'b0;
              row_q    <= '0;
              col_q    <= col_first;
              last_col <= CW'({1'b0, col_first} + col_count - (CW + 1)'(1));
              addr_q   <= BEAT_ADDR_WIDTH'(col_first) * BEAT_ADDR_WIDTH'(BPC);
              state    <= RUN;
            end
          end
        end
        RUN: begin
          if (issue) begin
            addr_q <= addr_q + BEAT_ADDR_WIDTH'(1);
            if (row_q == RW'(ROWS - LANES)) begin
              row_q <= '0;
              col_q <= col_q + CW'(1);
            end else begin
              row_q <= row_q + RW'(LANES);
            end
            if (beat_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Look one cycle ahead so done lands right after the final pop.
          if ((count_next == '0) && (inflight_next == '0)) begin
            state <= FINISH;
            done  <= 1'b1;
          end
        end
        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0..p(RAM_LATENCY-1): beat tags ride alongside the RAM read latency.
  always_ff @(posedge clock) begin
    if (reset || abort) begin
      tag_vld_p <= '0;
    end else begin
      tag_vld_p[0] <= issue;
      for (int k = 1; k < RAM_LATENCY; k++) tag_vld_p[k] <= tag_vld_p[k-1];
    end
  end

  always_ff @(posedge clock) begin
    tag_row_p[0]  <= row_q;
    tag_col_p[0]  <= col_q;
    tag_last_p[0] <= beat_last;
    for (int k = 1; k < RAM_LATENCY; k++) begin
      tag_row_p[k]  <= tag_row_p[k-1];
      tag_col_p[k]  <= tag_col_p[k-1];
      tag_last_p[k] <= tag_last_p[k-1];
    end
  end

  // Output buffer stage: returning RAM data joins its tag here.
  always_ff @(posedge clock) begin
    if (reset || abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count_next;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data[wr_ptr] <= ram_read_data;
      fifo_row[wr_ptr]  <= tag_row_p[RAM_LATENCY-1];
      fifo_col[wr_ptr]  <= tag_col_p[RAM_LATENCY-1];
      fifo_last[wr_ptr] <= tag_last_p[RAM_LATENCY-1];
    end
  end

  // Payload is forced to zero when nothing is buffered, which also gives the
  // reset values without resetting the storage.
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_row   = out_valid ? fifo_row[rd_ptr]  : '0;
  assign out_col   = out_valid ? fifo_col[rd_ptr]  : '0;
  assign out_last  = out_valid ? fifo_last[rd_ptr] : 1'b0;

endmodule

// File: doc/dictionary_stream_loader.md
# dictionary_stream_loader

Parametrised loader that streams a column-major dictionary RAM (word index = col*ROWS + row) into the dictionary processor's phi array over a valid/ready bus, LANES words per beat. It sits between `dict_ram` and `dict_processor`, replacing the single-word, no-backpressure `LOAD_SENSING_MATRIX` path. Beyond that path it adds a selectable column sub-range, multi-lane beats, downstream backpressure with a credit-limited read pipeline, range checking and abort.

## Interface
- DATA_WIDTH, 32, Q-format fixed-point word width (fp_32_t)
- ROWS, 64, signal size M (rows of phi)
- COLS, 256, dictionary size N (columns of phi)
- LANES, 1, words per RAM read and per output beat; power of two dividing ROWS
- RAM_LATENCY, 1, cycles from ram_read_en to valid ram_read_data; 1..4
- FIFO_DEPTH, RAM_LATENCY+2, output buffer depth in beats
- BEAT_ADDR_WIDTH, $clog2(ROWS*COLS/LANES), RAM beat-address width
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request, sampled only in IDLE
- abort  in  1  synchronous cancel, any state
- col_first  in  $clog2(COLS)  first column to load
- col_count  in  $clog2(COLS)+1  number of columns to load
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse on normal completion or range error
- error  out  1  range error flag, held until next accepted start
- ram_read_en  out  1  RAM read strobe
- ram_read_addr  out  BEAT_ADDR_WIDTH  beat address = (col*ROWS+row)/LANES
- ram_read_data  in  LANES*DATA_WIDTH  lane k = word row+k
- out_valid  out  1  beat available
- out_ready  in  1  processor accepts beat
- out_data  out  LANES*DATA_WIDTH  lane k → phi[out_row+k][out_col]
- out_row  out  $clog2(ROWS)  first row of beat
- out_col  out  $clog2(COLS)  column of beat
- out_last  out  1  final beat of transfer

## Operation
- States: IDLE, RUN, DRAIN, FINISH.
- IDLE: start with col_count==0 or col_first+col_count>COLS (compare at $clog2(COLS)+2 bits, no wrap) → error=1, FINISH, no RAM read. Otherwise error=0, latch range, row=0, col=col_first, → RUN.
- RUN: issue ram_read_en when occupancy + in-flight < FIFO_DEPTH. Order: row 0, LANES, …, ROWS−LANES within a column, then col+1. Issuing the last beat → DRAIN.
- Row/col/last tags travel in a RAM_LATENCY-deep shift register alongside the read. Returned data is written to the FIFO unconditionally; the credit rule guarantees no overflow.
- DRAIN: FIFO empty and no reads in flight → FINISH.
- FINISH: done=1 for one cycle → IDLE.
- out_valid = FIFO non-empty. A beat pops on out_valid&&out_ready. Simultaneous push and pop at full occupancy is legal; occupancy unchanged.
- out_last is set only on the beat at row ROWS−LANES of column col_first+col_count−1.
- abort (any state, takes priority over start): next cycle IDLE, FIFO flushed, in-flight tags cleared, their returning data discarded. No done. error unchanged.
- start while busy is ignored.
- Reset: state IDLE. busy, done, error, ram_read_en, out_valid, out_last = 0. ram_read_addr, out_data, out_row, out_col = 0.

## Timing
- start sampled at edge E0. First ram_read_en in cycle after E0.
- Data for a read issued in cycle t is captured at end of cycle t+RAM_LATENCY. out_valid appears in cycle t+RAM_LATENCY+1.
- Throughput: one beat per cycle with out_ready held high. Total beats B = col_count*ROWS/LANES.
- With out_ready constant 1: last beat pops in cycle B+RAM_LATENCY+1 after E0. done in the next cycle, busy low the cycle after done.
- Range error: done in cycle E0+1, error from E0+1.

## Test plan
- ROWS=8, COLS=4, LANES=2, RAM_LATENCY=1, RAM word i = i. Start col_first=0, col_count=4 with out_ready=1 → 16 beats; beat j has out_data lanes {2j, 2j+1}, out_row=(2j)%8, out_col=j/4. out_last only on beat 15. done in cycle 19 after E0.
- Same config, col_first=2, col_count=2 → 8 beats, addresses 8..15, out_col 2,2,2,2,3,3,3,3. error=0.
- col_first=3, col_count=2 → no ram_read_en, done and error high in cycle E0+1, busy low by E0+2. A following valid start clears error.
- out_ready toggling 1,0,0,1 repeating during a full load → never more than 3 beats buffered, no beat lost or duplicated, beat order identical to the first scenario.
- abort asserted 5 cycles into a full load → out_valid 0 and busy 0 next cycle, no done. A late RAM return is not emitted. A new start then yields all 16 beats correctly.
- reset asserted mid-RUN → all outputs at reset values next cycle. start asserted while busy is ignored (no second transfer).
